// File: rtl/anton_neopixel_bus_arbiter.sv
// ============================================================================
// anton_neopixel_bus_arbiter
// ----------------------------------------------------------------------------
// Shares the byte-wide register bus of the neopixel raw controller between
// two masters: requester 0 (APB host path) and requester 1 (animation /
// refresh engine). Arbitration is round-robin. A requester may hold its grant
// for back-to-back transactions with lockN. Read data is captured and returned
// separately for each requester.
//
// Parameters:
//   READ_LATENCY  cycles from busRead assertion to valid busDataOut (1..4)
//   LOCK_LIMIT    max consecutive locked re-grants (1..127); used only when
//                 ANTON_NEOPIXEL_ARB_LOCK_LIMIT_EN is defined
//
// Optional feature macro:
//   ANTON_NEOPIXEL_ARB_LOCK_LIMIT_EN  when defined, a locked requester gives
//                 up the bus after LOCK_LIMIT re-grants if the other requester
//                 is waiting. When undefined, lock is honoured indefinitely.
//
// Ports:
//   apbPclk, apbPresern       clock, asynchronous active-low reset
//   reqN, lockN, writeN       request, keep-grant, direction (1 = write)
//   addrN, wdataN             byte address and write data
//   ackN                      one-cycle completion pulse
//   rdataN                    read data, valid with ack, held until next read
//   busAddr, busDataIn        address / write data to the raw controller
//   busWrite, busRead         one-cycle strobes to the raw controller
//   busDataOut                read data from the raw controller
//   arbBusy                   high whenever the FSM is not IDLE
//   grantId                   requester currently owning the bus
// ============================================================================
module anton_neopixel_bus_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int LOCK_LIMIT   = 64
) (
    input  logic       apbPclk,
    input  logic       apbPresern,
    input  logic       req0,
    input  logic       req1,
    input  logic       lock0,
    input  logic       lock1,
    input  logic       write0,
    input  logic       write1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [7:0] busAddr,
    output logic [7:0] busDataIn,
    output logic       busWrite,
    output logic       busRead,
    input  logic [7:0] busDataOut,
    output logic       arbBusy,
    output logic       grantId
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

    // Index of the last WAIT cycle; only meaningful when READ_LATENCY > 1.
    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 2);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4 || LOCK_LIMIT < 1 || LOCK_LIMIT > 127) begin : gParamCheck
            $error("anton_neopixel_bus_arbiter: READ_LATENCY or LOCK_LIMIT out of range");
        end
    endgenerate

    stateT      state;
    logic       lastGrant;
    logic       writeLat;
    logic [1:0] waitCnt;

    logic       pickId;
    logic       launchId;
    logic       launchWrite;
    logic [7:0] launchAddr;
    logic [7:0] launchWdata;
    logic       grantLock;
    logic       grantReq;
    logic       holdGrant;

    // Round-robin pick in IDLE: a lone requester wins; on a tie the requester
    // that was not served last wins.
    assign pickId = req1 & (~req0 | ~lastGrant);

    // The requester whose inputs get latched: the arbitration winner in IDLE,
    // or the current owner when it re-launches directly from DONE.
    assign launchId    = (state == DONE) ? grantId : pickId;
    assign launchWrite = launchId ? write1 : write0;
    assign launchAddr  = launchId ? addr1  : addr0;
    assign launchWdata = launchId ? wdata1 : wdata0;

    assign grantLock = grantId ? lock1 : lock0;
    assign grantReq  = grantId ? req1  : req0;

    assign arbBusy = (state != IDLE);

`ifdef ANTON_NEOPIXEL_ARB_LOCK_LIMIT_EN
    logic [6:0] lockCnt;
    logic       otherReq;
    logic       limitHit;

    assign otherReq  = grantId ? req0 : req1;
    // The limit only bites when someone else is actually waiting.
    assign limitHit  = (lockCnt >= 7'(LOCK_LIMIT)) && otherReq;
    assign holdGrant = grantLock & grantReq & ~limitHit;

    always_ff @(posedge apbPclk or negedge apbPresern) begin
        if (!apbPresern) begin
            lockCnt <= '0;
        end else if (state == IDLE && (req0 || req1) && pickId != lastGrant) begin
            lockCnt <= '0;
        end else if (state == DONE) begin
            if (holdGrant) begin
                if (lockCnt != 7'h7F) begin
                    lockCnt <= lockCnt + 7'd1;
                end
            end else if (!grantLock) begin
                lockCnt <= '0;
            end
        end
    end
`else
    assign holdGrant = grantLock & grantReq;
`endif

    always_ff @(posedge apbPclk or negedge apbPresern) begin
        if (!apbPresern) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            writeLat  <= 1'b0;
            waitCnt   <= '0;
            grantId   <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            busAddr   <= '0;
            busDataIn <= '0;
            busWrite  <= 1'b0;
            busRead   <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses.
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busWrite <= 1'b0;
            busRead  <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        // busAddr/busDataIn double as the latched request
                        // registers and hold their value outside ISSUE.
                        grantId   <= launchId;
                        writeLat  <= launchWrite;
                        busAddr   <= launchAddr;
                        busDataIn <= launchWdata;
                        busWrite  <= launchWrite;
                        busRead   <= ~launchWrite;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    waitCnt <= '0;
                    if (writeLat) begin
                        ack0  <= ~grantId;
                        ack1  <= grantId;
                        state <= DONE;
                    end else if (READ_LATENCY == 1) begin
                        // Zero-length WAIT: data is valid during ISSUE.
                        if (grantId) rdata1 <= busDataOut;
                        else         rdata0 <= busDataOut;
                        ack0  <= ~grantId;
                        ack1  <= grantId;
                        state <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (waitCnt == WAIT_LAST) begin
                        if (grantId) rdata1 <= busDataOut;
                        else         rdata0 <= busDataOut;
                        ack0  <= ~grantId;
                        ack1  <= grantId;
                        state <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 2'd1;
                    end
                end

                DONE: begin
                    lastGrant <= grantId;
                    if (holdGrant) begin
                        // Locked burst: skip IDLE and arbitration entirely.
                        writeLat  <= launchWrite;
                        busAddr   <= launchAddr;
                        busDataIn <= launchWdata;
                        busWrite  <= launchWrite;
                        busRead   <= ~launchWrite;
                        state     <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
module tb_anton_neopixel_bus_arbiter;

    localparam int RL = 3;
    localparam int LL = 4;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic       write0 = 1'b0, write1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, busWrite, busRead, arbBusy, grantId;
    logic [7:0] rdata0, rdata1, busAddr, busDataIn, busDataOut;

    always #5 clk = ~clk;

    anton_neopixel_bus_arbiter #(
        .READ_LATENCY(RL),
        .LOCK_LIMIT  (LL)
    ) dut (
        .apbPclk   (clk),
        .apbPresern(rstN),
        .req0      (req0),
        .req1      (req1),
        .lock0     (lock0),
        .lock1     (lock1),
        .write0    (write0),
        .write1    (write1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .busAddr   (busAddr),
        .busDataIn (busDataIn),
        .busWrite  (busWrite),
        .busRead   (busRead),
        .busDataOut(busDataOut),
        .arbBusy   (arbBusy),
        .grantId   (grantId)
    );

    logic [2:0] rdVld = '0;
    always @(posedge clk) rdVld <= {rdVld[1:0], busRead};
    wire [3:0] vldChain = {rdVld, busRead};
    assign busDataOut = vldChain[RL-1] ? (busAddr ^ 8'h2C) : 8'hEE;

    typedef struct {
        bit         write;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         lock;
    } cmdT;

    typedef struct {
        bit         id;
        bit         write;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         gap;
    } expT;

    cmdT cmdQ0[$];
    cmdT cmdQ1[$];
    expT expQ[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int strobeCyc = 0;
    int lastAckCyc = 0;
    int strobeCnt = 0;

    function automatic void chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s", tag);
        end
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        expT e;
        cmdT c;
        if (rstN) begin
            if (busWrite || busRead) begin
                chk("strobe_exclusive", (busWrite & busRead) === 1'b0);
                chk("strobe_expected", expQ.size() > 0);
                if (expQ.size() > 0) begin
                    e = expQ[0];
                    chk("strobe_grant", grantId === e.id);
                    chk("strobe_dir", busWrite === e.write);
                    chk("strobe_addr", busAddr === e.addr);
                    if (e.write) chk("strobe_wdata", busDataIn === e.wdata);
                end
                strobeCyc = cyc;
                strobeCnt++;
            end
            if (ack0 || ack1) begin
                chk("ack_exclusive", (ack0 & ack1) === 1'b0);
                chk("ack_expected", expQ.size() > 0);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    chk("ack_id", ack1 === e.id);
                    chk("ack_strobes", strobeCnt == 1);
                    chk("ack_latency", (cyc - strobeCyc) == (e.write ? 1 : RL));
                    if (e.gap != 0) chk("ack_gap", (cyc - lastAckCyc) == e.gap);
                    if (!e.write) chk("ack_rdata", (e.id ? rdata1 : rdata0) === (e.addr ^ 8'h2C));
                    $display("txn id=%0d %s addr=0x%02h data=0x%02h cycle=%0d",
                             e.id, e.write ? "write" : "read", e.addr,
                             e.write ? e.wdata : (e.id ? rdata1 : rdata0), cyc);
                end
                lastAckCyc = cyc;
                strobeCnt  = 0;
            end
        end

        if (ack0 && cmdQ0.size() > 0) begin
            c = cmdQ0.pop_front();
            lock0 = c.lock;
        end else begin
            lock0 = (cmdQ0.size() > 0) ? cmdQ0[0].lock : 1'b0;
        end
        req0 = (cmdQ0.size() > 0);
        if (cmdQ0.size() > 0) begin
            write0 = cmdQ0[0].write;
            addr0  = cmdQ0[0].addr;
            wdata0 = cmdQ0[0].wdata;
        end

        if (ack1 && cmdQ1.size() > 0) begin
            c = cmdQ1.pop_front();
            lock1 = c.lock;
        end else begin
            lock1 = (cmdQ1.size() > 0) ? cmdQ1[0].lock : 1'b0;
        end
        req1 = (cmdQ1.size() > 0);
        if (cmdQ1.size() > 0) begin
            write1 = cmdQ1[0].write;
            addr1  = cmdQ1[0].addr;
            wdata1 = cmdQ1[0].wdata;
        end
    end

    task automatic cmd(input bit id, input bit wr, input logic [7:0] a, input logic [7:0] d, input bit lk);
        cmdT c;
        c.write = wr;
        c.addr  = a;
        c.wdata = d;
        c.lock  = lk;
        if (id) cmdQ1.push_back(c);
        else    cmdQ0.push_back(c);
    endtask

    task automatic expTxn(input bit id, input bit wr, input logic [7:0] a, input logic [7:0] d, input int gap);
        expT e;
        e.id    = id;
        e.write = wr;
        e.addr  = a;
        e.wdata = d;
        e.gap   = gap;
        expQ.push_back(e);
    endtask

    task automatic flushAll();
        cmdQ0.delete();
        cmdQ1.delete();
        expQ.delete();
        strobeCnt = 0;
        req0  = 1'b0;
        req1  = 1'b0;
        lock0 = 1'b0;
        lock1 = 1'b0;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        flushAll();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {ack0, ack1, busWrite, busRead, arbBusy, grantId, busAddr, busDataIn, rdata0, rdata1} === 38'h0);
        rstN = 1'b1;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while ((expQ.size() != 0 || cmdQ0.size() != 0 || cmdQ1.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", n < 500);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_drain", {arbBusy, busWrite, busRead, ack0, ack1} === 5'b0);
    endtask

    initial begin
        int n;

        doReset();
        cmd(0, 1'b1, 8'h05, 8'hA5, 1'b0);
        expTxn(0, 1'b1, 8'h05, 8'hA5, 0);
        waitDone();

        doReset();
        cmd(0, 1'b1, 8'h11, 8'hB1, 1'b0);
        cmd(0, 1'b1, 8'h12, 8'hB2, 1'b0);
        cmd(1, 1'b1, 8'h21, 8'hC1, 1'b0);
        cmd(1, 1'b1, 8'h22, 8'hC2, 1'b0);
        expTxn(0, 1'b1, 8'h11, 8'hB1, 0);
        expTxn(1, 1'b1, 8'h21, 8'hC1, 3);
        expTxn(0, 1'b1, 8'h12, 8'hB2, 3);
        expTxn(1, 1'b1, 8'h22, 8'hC2, 3);
        waitDone();

        doReset();
        cmd(0, 1'b0, 8'h22, 8'h00, 1'b0);
        expTxn(0, 1'b0, 8'h22, 8'h00, 0);
        @(posedge clk);
        #1;
        cmd(1, 1'b0, 8'h10, 8'h00, 1'b0);
        cmd(1, 1'b1, 8'h30, 8'hD3, 1'b0);
        expTxn(1, 1'b0, 8'h10, 8'h00, 2 + RL);
        expTxn(1, 1'b1, 8'h30, 8'hD3, 3);
        waitDone();
        chk("rdata0_held", rdata0 === 8'h0E);
        chk("rdata1_held", rdata1 === 8'h3C);

        doReset();
        for (int i = 0; i < 5; i++) cmd(0, 1'b1, 8'(8'h40 + i), 8'(8'h80 + i), i < 4);
        @(posedge clk);
        #1;
        cmd(1, 1'b1, 8'h50, 8'hE5, 1'b0);
        for (int i = 0; i < 5; i++) expTxn(0, 1'b1, 8'(8'h40 + i), 8'(8'h80 + i), (i == 0) ? 0 : 2);
        expTxn(1, 1'b1, 8'h50, 8'hE5, 3);
        waitDone();

        doReset();
        for (int i = 0; i < 8; i++) cmd(0, 1'b1, 8'(8'h60 + i), 8'(8'h90 + i), i < 7);
        @(posedge clk);
        #1;
        cmd(1, 1'b1, 8'h70, 8'hA0, 1'b0);
`ifdef ANTON_NEOPIXEL_ARB_LOCK_LIMIT_EN
        for (int i = 0; i < 5; i++) expTxn(0, 1'b1, 8'(8'h60 + i), 8'(8'h90 + i), (i == 0) ? 0 : 2);
        expTxn(1, 1'b1, 8'h70, 8'hA0, 3);
        for (int i = 5; i < 8; i++) expTxn(0, 1'b1, 8'(8'h60 + i), 8'(8'h90 + i), (i == 5) ? 3 : 2);
`else
        for (int i = 0; i < 8; i++) expTxn(0, 1'b1, 8'(8'h60 + i), 8'(8'h90 + i), (i == 0) ? 0 : 2);
        expTxn(1, 1'b1, 8'h70, 8'hA0, 3);
`endif
        waitDone();

        doReset();
        cmd(0, 1'b0, 8'h44, 8'h00, 1'b0);
        expTxn(0, 1'b0, 8'h44, 8'h00, 0);
        n = 0;
        while (!busRead && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("read_issue_seen", busRead === 1'b1);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        flushAll();
        #1;
        chk("async_reset_outputs", {ack0, ack1, busWrite, busRead, arbBusy, grantId, busAddr, busDataIn, rdata0, rdata1} === 38'h0);
        repeat (3) begin
            @(negedge clk);
            chk("no_ack_in_reset", (ack0 | ack1) === 1'b0);
        end
        @(posedge clk);
        #1;
        rstN = 1'b1;
        cmd(0, 1'b0, 8'h44, 8'h00, 1'b0);
        expTxn(0, 1'b0, 8'h44, 8'h00, 0);
        waitDone();
        chk("rdata0_after_reset", rdata0 === 8'h68);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
